// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Resolves one conditional branch or jump per accepted request.
//            It produces the taken decision, the next PC, and the flags for
//            mispredict, misaligned target and illegal compare code. The
//            result sits in a one-entry output register with pass-through
//            back-pressure.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready       - request handshake
//            br_op, is_jump          - compare code / unconditional jump
//            operand_a/b, pc, imm    - compare operands, branch PC, offset
//            pred_taken              - front-end prediction
//            out_valid/out_ready     - result handshake
//            taken, next_pc, mispredict, misaligned, illegal - result fields
//            taken_cnt, mispredict_cnt (16b) - only with BRANCH_RESOLVE_STATS_EN
// Config   : define BRANCH_RESOLVE_STATS_EN to add saturating statistics
//            counters for taken and mispredicted results.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic             is_jump,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc,
  output logic             mispredict,
  output logic             misaligned,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic             illegal,
  output logic [15:0]      taken_cnt,
  output logic [15:0]      mispredict_cnt
`else
  output logic             illegal
`endif
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;
  localparam logic [2:0] OP_GEU = 3'b111;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic             mispredict_q, mispredict_d;
  logic             misaligned_q, misaligned_d;
  logic             illegal_q, illegal_d;

  logic             cmp_res;
  logic             op_illegal;
  logic             res_taken;
  logic             res_illegal;
  logic             res_misaligned;
  logic [WIDTH-1:0] res_next_pc;
  logic             accept;
  logic             out_fire;

  // Compare stage: decode br_op and evaluate the condition.
  always_comb begin
    cmp_res    = 1'b0;
    op_illegal = 1'b0;
    case (br_op)
      OP_EQ:   cmp_res = (operand_a == operand_b);
      OP_NE:   cmp_res = (operand_a != operand_b);
      OP_LT:   cmp_res = ($signed(operand_a) <  $signed(operand_b));
      OP_GE:   cmp_res = ($signed(operand_a) >= $signed(operand_b));
      OP_LTU:  cmp_res = (operand_a <  operand_b);
      OP_GEU:  cmp_res = (operand_a >= operand_b);
      default: op_illegal = 1'b1;
    endcase
  end

  // Result formation. An illegal code never takes the branch, so the
  // sequential PC is reported and the request is flagged as a mispredict
  // so the front end redirects.
  always_comb begin
    res_illegal    = !is_jump && op_illegal;
    res_taken      = is_jump || (!op_illegal && cmp_res);
    res_next_pc    = res_taken ? (pc + imm) : (pc + PC_STEP);
    res_misaligned = res_taken && (res_next_pc[1:0] != 2'b00);
  end

  // A new request may enter whenever the slot is empty or drains this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    next_pc_d    = next_pc_q;
    mispredict_d = mispredict_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    if (accept) begin
      // Loading on the same edge as a drain keeps the stream bubble-free.
      valid_d      = 1'b1;
      taken_d      = res_taken;
      next_pc_d    = res_next_pc;
      mispredict_d = (res_taken ^ pred_taken) || res_misaligned || res_illegal;
      misaligned_d = res_misaligned;
      illegal_d    = res_illegal;
    end else if (out_fire) begin
      valid_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      next_pc_q    <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      next_pc_q    <= next_pc_d;
      mispredict_q <= mispredict_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  // Flags are masked while the slot is empty so stale results never leak.
  assign out_valid  = valid_q;
  assign taken      = valid_q && taken_q;
  assign next_pc    = next_pc_q;
  assign mispredict = valid_q && mispredict_q;
  assign misaligned = valid_q && misaligned_q;
  assign illegal    = valid_q && illegal_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    taken_cnt_d      = taken_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (out_fire && taken_q && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (out_fire && mispredict_q && (mispredict_cnt_q != 16'hFFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q      <= 16'd0;
      mispredict_cnt_q <= 16'd0;
    end else begin
      taken_cnt_q      <= taken_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign taken_cnt      = taken_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve
// Purpose  : Scoreboard bench for branch_resolve (WIDTH = 32). The driver
//            issues directed requests, each carrying its hand-computed result.
//            The monitor queues that result when the request is accepted. It
//            pops and compares the result when the output handshakes. It also
//            models out_valid timing, output stability and reset values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  br_op = 3'b000;
  logic        is_jump = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0, pc = '0, imm = '0;
  logic        pred_taken = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        taken, mispredict, misaligned, illegal;
  logic [31:0] next_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] taken_cnt, mispredict_cnt;
`endif

  branch_resolve #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .is_jump(is_jump),
    .operand_a(operand_a), .operand_b(operand_b), .pc(pc), .imm(imm),
    .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .next_pc(next_pc), .mispredict(mispredict),
    .misaligned(misaligned),
`ifdef BRANCH_RESOLVE_STATS_EN
    .illegal(illegal),
    .taken_cnt(taken_cnt), .mispredict_cnt(mispredict_cnt)
`else
    .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        t;
    logic [31:0] npc;
    logic        mp;
    logic        ma;
    logic        il;
  } res_t;

  res_t exp_pending = '0;
  res_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic to_flag = 1'b0;
  logic to_seen = 1'b0;
  logic end_chk = 1'b0;
  logic end_done = 1'b0;

  // ---------------- monitor / scoreboard (sole owner of the counters) ------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic        acc_prev = 1'b0, ov_prev = 1'b0, ordy_prev = 1'b0;
  logic        p_t = 1'b0, p_mp = 1'b0, p_ma = 1'b0, p_il = 1'b0;
  logic [31:0] p_npc = '0;
  logic        exp_ov;
  res_t        r;
  int          m_tcnt = 0, m_mcnt = 0;

  always @(negedge clk) begin
    if (to_flag && !to_seen) begin
      to_seen = 1'b1;
      chk("accept_timeout", 32'd1, 32'd0);
    end
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_flags", {28'd0, taken, mispredict, misaligned, illegal}, 32'd0);
      chk("rst_next_pc", next_pc, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
      chk("rst_misp_cnt", {16'd0, mispredict_cnt}, 32'd0);
`endif
      sb.delete();
      acc_prev = 1'b0; ov_prev = 1'b0; ordy_prev = 1'b0;
      m_tcnt = 0; m_mcnt = 0;
    end else begin
      exp_ov = acc_prev || (ov_prev && !ordy_prev);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_ov || out_ready)});
      if (ov_prev && !ordy_prev && out_valid)
        chk("stable", {next_pc[27:0], taken, mispredict, misaligned, illegal},
            {p_npc[27:0], p_t, p_mp, p_ma, p_il});
      if (!out_valid)
        chk("idle_flags", {28'd0, taken, mispredict, misaligned, illegal}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("taken_cnt", {16'd0, taken_cnt}, m_tcnt);
      chk("misp_cnt", {16'd0, mispredict_cnt}, m_mcnt);
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("taken", {31'd0, taken}, {31'd0, r.t});
          chk("next_pc", next_pc, r.npc);
          chk("mispredict", {31'd0, mispredict}, {31'd0, r.mp});
          chk("misaligned", {31'd0, misaligned}, {31'd0, r.ma});
          chk("illegal", {31'd0, illegal}, {31'd0, r.il});
          if (r.t && m_tcnt < 65535) m_tcnt++;
          if (r.mp && m_mcnt < 65535) m_mcnt++;
        end
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) sb.push_back(exp_pending);
      ov_prev = out_valid; ordy_prev = out_ready;
      p_t = taken; p_mp = mispredict; p_ma = misaligned; p_il = illegal; p_npc = next_pc;
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      chk("sb_drained", sb.size(), 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] op, input logic j,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] im, input logic pr,
                      input logic et, input logic [31:0] enp,
                      input logic emp, input logic ema, input logic eil);
    int n;
    br_op = op; is_jump = j; operand_a = a; operand_b = b;
    pc = p; imm = im; pred_taken = pr;
    exp_pending = '{t: et, npc: enp, mp: emp, ma: ema, il: eil};
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        to_flag = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // BEQ equal: taken, predicted not-taken -> mispredict
    send(3'b000, 0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1, 32'h120, 1, 0, 0);
    // BLT vs BLTU with -1 vs 1
    send(3'b100, 0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1, 1, 32'h240, 0, 0, 0);
    send(3'b110, 0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 0, 0, 32'h204, 0, 0, 0);
    // BNE / BGE / BGEU
    send(3'b001, 0, 32'd7, 32'd5, 32'h300, 32'hFFFFFFF0, 1, 1, 32'h2F0, 0, 0, 0);
    send(3'b101, 0, 32'h80000000, 32'd0, 32'h400, 32'h10, 1, 0, 32'h404, 1, 0, 0);
    send(3'b111, 0, 32'h80000000, 32'd0, 32'h400, 32'h10, 1, 1, 32'h410, 0, 0, 0);
    // Illegal code, misaligned jump, PC wrap on fall-through
    send(3'b010, 0, 32'd1, 32'd1, 32'h500, 32'h8, 0, 0, 32'h504, 1, 0, 1);
    send(3'b011, 1, 32'd0, 32'd0, 32'h100, 32'h2, 1, 1, 32'h102, 1, 1, 0);
    send(3'b001, 0, 32'd9, 32'd9, 32'hFFFFFFFC, 32'h40, 0, 0, 32'h0, 0, 0, 0);

    // Back-pressure: hold the consumer off for three cycles with B waiting
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'b000, 0, 32'd1, 32'd2, 32'h600, 32'h8, 0, 0, 32'h604, 0, 0, 0);
    fork
      send(3'b100, 0, 32'd1, 32'd2, 32'h700, 32'h8, 0, 1, 32'h708, 1, 0, 0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Streaming: eight back-to-back requests
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        send(3'b000, 0, i, 32'd3, 32'h1000 + 16 * i, 32'h8, 0,
             1, 32'h1000 + 16 * i + 8, 1, 0, 0);
      else
        send(3'b000, 0, i, 32'd3, 32'h1000 + 16 * i, 32'h8, 0,
             0, 32'h1000 + 16 * i + 4, 0, 0, 0);
    end

    // Reset while a result is pending
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'b000, 0, 32'd4, 32'd4, 32'h800, 32'h10, 0, 1, 32'h810, 1, 0, 0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    // Accepted on the first edge after release
    send(3'b001, 0, 32'd1, 32'd2, 32'h900, 32'h20, 1, 1, 32'h920, 0, 0, 0);

`ifdef BRANCH_RESOLVE_STATS_EN
    // Drive both counters into saturation with taken, mispredicted jumps
    for (int i = 0; i < 65540; i++)
      send(3'b000, 1, 32'd0, 32'd0, 32'h100, 32'h8, 0, 1, 32'h108, 1, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1 end_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, PC and immediate width (minimum 8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port br_op  input  3  compare code: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010 and 011 illegal.
REQ-007 SHALL have port is_jump  input  1  unconditional jump; br_op ignored.
REQ-008 SHALL have ports operand_a, operand_b, pc, imm  input  WIDTH each  compare operands, branch PC, sign-extended offset.
REQ-009 SHALL have port pred_taken  input  1  front-end prediction for this request.
REQ-010 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result when out_valid is high.
REQ-012 SHALL have ports taken  output  1, next_pc  output  WIDTH, mispredict  output  1, misaligned  output  1, illegal  output  1.

Function
REQ-013 SHALL drive in_ready = !out_valid || out_ready (combinational; one-entry pipeline with pass-through back-pressure).
REQ-014 SHALL capture an accepted request's results into the output register, giving a latency of exactly one cycle to out_valid.
REQ-015 SHALL compute taken = 1 when is_jump is high, otherwise the br_op compare, with signed compare for LT/GE and unsigned compare for LTU/GEU.
REQ-016 SHALL compute next_pc = pc + imm (mod 2^WIDTH) when taken, otherwise pc + 4 (mod 2^WIDTH); wrap-around is not flagged.
REQ-017 SHALL set misaligned when taken and next_pc[1:0] != 0; SHALL clear it when not taken.
REQ-018 SHALL set mispredict = taken XOR pred_taken, or 1 whenever misaligned or illegal is set.
REQ-019 SHALL, on an illegal br_op with is_jump low, set illegal = 1 and taken = 0, and set next_pc = pc + 4.
REQ-020 SHALL hold all output fields stable while out_valid is high and out_ready is low.
REQ-021 SHALL clear out_valid after a handshake when no new request is accepted in the same cycle.
REQ-022 SHALL, when the output handshake and the input handshake occur in the same cycle, load the new result with out_valid staying high (no bubble).
REQ-023 SHALL drive taken, mispredict, misaligned and illegal to 0 whenever out_valid is low; next_pc is don't-care then.

Reset
REQ-024 SHALL, while rst_n is low, immediately force out_valid=0, taken=0, mispredict=0, misaligned=0, illegal=0, next_pc=0, and all counters to 0.
REQ-025 SHALL discard any result pending when reset asserts mid-operation; in_ready SHALL be high during reset.
REQ-026 SHALL accept a request on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro BRANCH_RESOLVE_STATS_EN is defined, provide outputs taken_cnt and mispredict_cnt (16 bits each).
REQ-028 SHALL, with BRANCH_RESOLVE_STATS_EN, increment each counter by one for each output handshake whose taken or mispredict bit is set, saturating at 16'hFFFF.
REQ-029 SHALL, without BRANCH_RESOLVE_STATS_EN, omit the counter ports and logic entirely; all other behaviour is identical.

Verification
REQ-030 Bench SHALL cover BEQ: a=5, b=5, pc=0x100, imm=0x20, pred_taken=0 -> one cycle later out_valid=1, taken=1, next_pc=0x120, mispredict=1.
REQ-031 Bench SHALL cover BLT vs BLTU: a=0xFFFFFFFF, b=1 -> BLT taken=1; BLTU taken=0, next_pc=pc+4.
REQ-032 Bench SHALL cover back-pressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, outputs stable; then out_ready=1 -> result consumed, the next result is valid the following cycle.
REQ-033 Bench SHALL cover boundaries: br_op=010 -> illegal=1, mispredict=1, taken=0; is_jump with imm=0x2 -> misaligned=1; pc=0xFFFFFFFC, not taken -> next_pc=0.
REQ-034 Bench SHALL cover back-to-back streaming: in_valid and out_ready high for 8 cycles -> 8 results on 8 consecutive cycles, no bubbles.
REQ-035 Bench SHALL cover reset mid-operation: rst_n low while out_valid=1 -> out_valid=0 immediately; with BRANCH_RESOLVE_STATS_EN, counters read 0 and saturate at 0xFFFF.
